// File: rtl/alu_accumulator_if.sv
// Operation/result bundle of alu_accumulator: request handshake in, accumulator and flags out.
interface alu_accumulator_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   a;
    logic [2:0]         fn;
    logic               in_valid;
    logic               in_ready;
    logic               clear;
    logic [2*WIDTH-1:0] acc;
    logic               out_valid;
    logic               carry;
    logic               zero;

    modport master (
        output a, fn, in_valid, clear,
        input  in_ready, acc, out_valid, carry, zero
    );

    modport slave (
        input  a, fn, in_valid, clear,
        output in_ready, acc, out_valid, carry, zero
    );
endinterface

// File: rtl/alu_accumulator.sv
// WIDTH-bit ALU with a 2*WIDTH-bit accumulator feedback and an iterative shift-add multiplier.
// Optional registered carry/zero flags are built only when ALU_ACC_FLAGS_EN is defined.
module alu_accumulator #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    alu_accumulator_if.slave bus
);
    localparam int AW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [2:0] FN_INC = 3'b000;
    localparam logic [2:0] FN_ADD = 3'b001;
    localparam logic [2:0] FN_SUB = 3'b010;
    localparam logic [2:0] FN_LOG = 3'b011;
    localparam logic [2:0] FN_AND = 3'b100;
    localparam logic [2:0] FN_SHL = 3'b101;
    localparam logic [2:0] FN_SHR = 3'b110;
    localparam logic [2:0] FN_MUL = 3'b111;

    // Single-cycle result; operands are zero-extended to the accumulator width.
    function automatic logic [AW-1:0] alu_result(
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b,
        input logic [2:0]       op_fn
    );
        logic [AW-1:0] a_x;
        logic [AW-1:0] b_x;
        logic          oob;
        a_x = AW'(op_a);
        b_x = AW'(op_b);
        oob = (32'(op_a) >= 32'(AW));
        case (op_fn)
            FN_INC:  alu_result = a_x + AW'(1'b1);
            FN_ADD:  alu_result = a_x + b_x;
            FN_SUB:  alu_result = a_x - b_x;
            FN_LOG:  alu_result = {op_a | op_b, op_a ^ op_b};
            FN_AND:  alu_result = AW'(|(op_a & op_b));
            FN_SHL:  alu_result = oob ? {AW{1'b0}} : (b_x << op_a);
            FN_SHR:  alu_result = oob ? {AW{1'b0}} : (b_x >> op_a);
            default: alu_result = {AW{1'b0}};
        endcase
    endfunction

    logic [0:0]       state_q, state_d;
    logic             ready_q, ready_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [AW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [AW-1:0]    psum_q, psum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] op_b_s;
    logic [AW-1:0]    alu_res_s;
    logic [AW-1:0]    mul_step_s;
    logic             accept_s;
    logic             mul_last_s;

    assign op_b_s     = acc_q[WIDTH-1:0];
    assign alu_res_s  = alu_result(bus.a, op_b_s, bus.fn);
    assign accept_s   = bus.in_valid & ready_q;
    assign mul_step_s = psum_q + (mplier_q[0] ? mcand_q : {AW{1'b0}});
    assign mul_last_s = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state: clear beats everything, then accept (IDLE) or one multiply iteration (MUL).
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        psum_d      = psum_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear) begin
                    acc_d = {AW{1'b0}};
                end else if (accept_s) begin
                    if (bus.fn == FN_MUL) begin
                        mcand_d  = AW'(bus.a);
                        mplier_d = op_b_s;
                        psum_d   = {AW{1'b0}};
                        cnt_d    = {CNT_W{1'b0}};
                        state_d  = ST_MUL;
                    end else begin
                        acc_d       = alu_res_s;
                        out_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (bus.clear) begin
                    acc_d   = {AW{1'b0}};
                    state_d = ST_IDLE;
                end else if (mul_last_s) begin
                    acc_d       = mul_step_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    psum_d   = mul_step_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Datapath and control registers; reset aborts any multiply immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            acc_q       <= {AW{1'b0}};
            out_valid_q <= 1'b0;
            mcand_q     <= {AW{1'b0}};
            mplier_q    <= {WIDTH{1'b0}};
            psum_q      <= {AW{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            psum_q      <= psum_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.acc       = acc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = ready_q;

`ifdef ALU_ACC_FLAGS_EN
    // Carry out of bit WIDTH for increment/add, borrow for subtract, 0 otherwise.
    function automatic logic alu_carry(
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b,
        input logic [2:0]       op_fn
    );
        logic [WIDTH:0] sum;
        case (op_fn)
            FN_INC: begin
                sum       = {1'b0, op_a} + (WIDTH + 1)'(1'b1);
                alu_carry = sum[WIDTH];
            end
            FN_ADD: begin
                sum       = {1'b0, op_a} + {1'b0, op_b};
                alu_carry = sum[WIDTH];
            end
            FN_SUB:  alu_carry = (op_a < op_b);
            default: alu_carry = 1'b0;
        endcase
    endfunction

    logic carry_q, carry_d;
    logic zero_q, zero_d;

    // Flags follow every acc write; a multiply result never carries.
    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (bus.clear) begin
            carry_d = 1'b0;
            zero_d  = 1'b1;
        end else if (out_valid_d) begin
            carry_d = (state_q == ST_IDLE) ? alu_carry(bus.a, op_b_s, bus.fn) : 1'b0;
            zero_d  = (acc_d == {AW{1'b0}});
        end else begin
            carry_d = carry_q;
        end
    end

    // Flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.carry = carry_q;
    assign bus.zero  = zero_q;
`else
    assign bus.carry = 1'b0;
    assign bus.zero  = 1'b0;
`endif
endmodule

// File: tb/tb_alu_accumulator.sv
// Self-checking bench for alu_accumulator (WIDTH=4): vector table, multiply/clear/reset sequences.
module tb_alu_accumulator;
    localparam int WIDTH = 4;
`ifdef ALU_ACC_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clock;
    logic reset;

    alu_accumulator_if #(.WIDTH(WIDTH)) bus_if ();

    alu_accumulator #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] a;
        logic [2:0] fn;
        logic [7:0] acc;
        logic       carry;
        logic       zero;
    } vec_t;

    typedef struct {
        logic [7:0] acc;
        logic       carry;
        logic       zero;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[20];
    int   checks = 0;
    int   errors = 0;
    int   low_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " acc"}, 32'(bus_if.acc), 32'h0);
        check({tag, " in_ready"}, 32'(bus_if.in_ready), 32'h1);
        check({tag, " out_valid"}, 32'(bus_if.out_valid), 32'h0);
        check({tag, " carry"}, 32'(bus_if.carry), 32'h0);
        check({tag, " zero"}, 32'(bus_if.zero), 32'(FLAGS));
    endtask

    task automatic issue(input logic [3:0] a, input logic [2:0] fn, input logic [7:0] eacc,
                         input logic ec, input logic ez, input bit push);
        exp_t e;
        @(posedge clock);
        #1;
        bus_if.a        = a;
        bus_if.fn       = fn;
        bus_if.in_valid = 1'b1;
        if (push) begin
            e.acc   = eacc;
            e.carry = FLAGS ? ec : 1'b0;
            e.zero  = FLAGS ? ez : 1'b0;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    // Multiply with a junk request held during the busy window; counts in_ready-low cycles.
    task automatic do_mul(input logic [3:0] a, input logic [7:0] eacc);
        issue(a, 3'b111, eacc, 1'b0, (eacc == 8'h00), 1'b1);
        @(posedge clock);
        #1;
        bus_if.a        = 4'h1;
        bus_if.fn       = 3'b001;
        bus_if.in_valid = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus_if.in_ready) break;
            low_cnt++;
        end
        bus_if.in_valid = 1'b0;
        check("mul in_ready low cycles", 32'(low_cnt), 32'd4);
    endtask

    // Scoreboard: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset === 1'b0 && bus_if.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected out_valid", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result acc", 32'(bus_if.acc), 32'(e.acc));
                check("result carry", 32'(bus_if.carry), 32'(e.carry));
                check("result zero", 32'(bus_if.zero), 32'(e.zero));
            end
        end
    end

    initial begin
        vecs[0]  = '{4'h5, 3'b001, 8'h05, 1'b0, 1'b0};
        vecs[1]  = '{4'hF, 3'b001, 8'h14, 1'b1, 1'b0};
        vecs[2]  = '{4'h3, 3'b010, 8'hFF, 1'b1, 1'b0};
        vecs[3]  = '{4'h0, 3'b100, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{4'h5, 3'b000, 8'h06, 1'b0, 1'b0};
        vecs[5]  = '{4'h3, 3'b011, 8'h75, 1'b0, 1'b0};
        vecs[6]  = '{4'h3, 3'b010, 8'hFE, 1'b1, 1'b0};
        vecs[7]  = '{4'hF, 3'b000, 8'h10, 1'b1, 1'b0};
        vecs[8]  = '{4'h1, 3'b001, 8'h01, 1'b0, 1'b0};
        vecs[9]  = '{4'h3, 3'b101, 8'h08, 1'b0, 1'b0};
        vecs[10] = '{4'h4, 3'b101, 8'h80, 1'b0, 1'b0};
        vecs[11] = '{4'h8, 3'b000, 8'h09, 1'b0, 1'b0};
        vecs[12] = '{4'hA, 3'b101, 8'h00, 1'b0, 1'b1};
        vecs[13] = '{4'hF, 3'b011, 8'hFF, 1'b0, 1'b0};
        vecs[14] = '{4'h8, 3'b110, 8'h00, 1'b0, 1'b1};
        vecs[15] = '{4'hE, 3'b000, 8'h0F, 1'b0, 1'b0};
        vecs[16] = '{4'h2, 3'b110, 8'h03, 1'b0, 1'b0};
        vecs[17] = '{4'h6, 3'b100, 8'h01, 1'b0, 1'b0};
        vecs[18] = '{4'hC, 3'b001, 8'h0D, 1'b0, 1'b0};
        vecs[19] = '{4'h0, 3'b110, 8'h0D, 1'b0, 1'b0};

        reset           = 1'b1;
        bus_if.a        = 4'h0;
        bus_if.fn       = 3'b000;
        bus_if.in_valid = 1'b0;
        bus_if.clear    = 1'b0;
        @(negedge clock);
        check_idle_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // Back-to-back single-cycle operations, one accept per clock.
        for (int i = 0; i < 20; i++) begin
            issue(vecs[i].a, vecs[i].fn, vecs[i].acc, vecs[i].carry, vecs[i].zero, 1'b1);
        end
        idle();

        do_mul(4'hB, 8'h8F);
        do_mul(4'hF, 8'hE1);
        @(negedge clock);
        check("acc hold after mul", 32'(bus_if.acc), 32'h0E1);

        // Clear two iterations into a multiply.
        issue(4'h5, 3'b111, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        bus_if.in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        bus_if.clear = 1'b1;
        @(posedge clock);
        #1;
        bus_if.clear = 1'b0;
        @(negedge clock);
        check_idle_zero("clear in mul");
        repeat (6) @(negedge clock);
        check("acc after aborted mul", 32'(bus_if.acc), 32'h0);

        // Clear in IDLE discards a simultaneous accept.
        issue(4'h7, 3'b000, 8'h08, 1'b0, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        bus_if.clear    = 1'b1;
        bus_if.a        = 4'h3;
        bus_if.fn       = 3'b001;
        bus_if.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus_if.clear    = 1'b0;
        bus_if.in_valid = 1'b0;
        @(negedge clock);
        check_idle_zero("clear in idle");

        // Asynchronous reset in the middle of a multiply cycle.
        issue(4'h6, 3'b000, 8'h07, 1'b0, 1'b0, 1'b1);
        issue(4'h3, 3'b111, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        bus_if.in_valid = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_idle_zero("async reset in mul");
        @(posedge clock);
        #2;
        reset = 1'b0;
        issue(4'h9, 3'b000, 8'h0A, 1'b0, 1'b0, 1'b1);
        idle();

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clock);
        check("scoreboard drained", 32'(sb_q.size()), 32'h0);
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
